// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the ARM-subset datapath.
// Drives datapath mux selects and strobes, and runs the MOV/MOC handshake with a MOC watchdog.
module ctrl_sequencer #(
    parameter int unsigned MOC_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir,
    input  logic        cond_ok,
    input  logic        moc,
    output logic [1:0]  ma,
    output logic [1:0]  mb,
    output logic [2:0]  mc,
    output logic        md,
    output logic        me,
    output logic        mg,
    output logic [1:0]  mj,
    output logic [4:0]  op,
    output logic        rf_ld,
    output logic        ir_ld,
    output logic        mar_ld,
    output logic        mdr_ld,
    output logic        flags_ld,
    output logic        mem_en,
    output logic        mem_rw,
    output logic        fault,
    output logic [4:0]  state
);

    localparam logic [4:0] S_IDLE     = 5'd0;
    localparam logic [4:0] S_FETCH0   = 5'd1;
    localparam logic [4:0] S_FETCH1   = 5'd2;
    localparam logic [4:0] S_FETCH2   = 5'd3;
    localparam logic [4:0] S_DECODE   = 5'd4;
    localparam logic [4:0] S_DP       = 5'd5;
    localparam logic [4:0] S_MEM_ADDR = 5'd6;
    localparam logic [4:0] S_LDR_WAIT = 5'd7;
    localparam logic [4:0] S_LDR_WB   = 5'd8;
    localparam logic [4:0] S_STR_WAIT = 5'd9;
    localparam logic [4:0] S_BL_LINK  = 5'd10;
    localparam logic [4:0] S_BR       = 5'd11;
    localparam logic [4:0] S_FAULT    = 5'd31;

    localparam logic [4:0] OP_ADD    = 5'h04;
    localparam logic [4:0] OP_SUB    = 5'h02;
    localparam logic [4:0] OP_PASS_A = 5'h10;
    localparam logic [4:0] OP_ADD4   = 5'h11;
    localparam logic [4:0] OP_PASS_B = 5'h12;

    localparam logic [7:0] WD_LAST = 8'(MOC_TIMEOUT - 1);

    logic [4:0] state_q, state_d;
    logic [7:0] wd_cnt_q, wd_cnt_d;
    logic       in_wait;
    logic       wd_expired;
    logic       unused_ir;

    // Condition field and operand fields are resolved elsewhere in the datapath.
    assign unused_ir = ^{ir[31:28], ir[22:21], ir[19:0]};

    assign in_wait    = (state_q == S_FETCH2) || (state_q == S_LDR_WAIT) || (state_q == S_STR_WAIT);
    assign wd_expired = in_wait && !moc && (wd_cnt_q == WD_LAST);
    assign state      = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wd_cnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    // Counter is zero in every non-waiting cycle, so entering a wait state starts it from zero.
    always_comb begin
        state_d  = state_q;
        wd_cnt_d = 8'd0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH0;
            S_FETCH0: state_d = S_FETCH1;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2, S_LDR_WAIT, S_STR_WAIT: begin
                if (moc) begin
                    if (state_q == S_FETCH2)        state_d = S_DECODE;
                    else if (state_q == S_LDR_WAIT) state_d = S_LDR_WB;
                    else                            state_d = S_FETCH0;
                end else if (wd_expired) begin
                    state_d = S_FAULT;
                end else begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (!cond_ok)                state_d = S_FETCH0;
                else if (ir[27:26] == 2'b00) state_d = S_DP;
                else if (ir[27:25] == 3'b010) state_d = S_MEM_ADDR;
                else if (ir[27:25] == 3'b101) state_d = ir[24] ? S_BL_LINK : S_BR;
                else                         state_d = S_FETCH0;
            end
            S_DP:       state_d = S_FETCH0;
            S_MEM_ADDR: state_d = ir[20] ? S_LDR_WAIT : S_STR_WAIT;
            S_LDR_WB:   state_d = S_FETCH0;
            S_BL_LINK:  state_d = S_BR;
            S_BR:       state_d = S_FETCH0;
            S_FAULT:    state_d = S_FAULT;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ma = 2'd0; mb = 2'd0; mc = 3'd0; md = 1'b0; me = 1'b0; mg = 1'b0; mj = 2'd0;
        op = 5'd0;
        rf_ld = 1'b0; ir_ld = 1'b0; mar_ld = 1'b0; mdr_ld = 1'b0; flags_ld = 1'b0;
        mem_en = 1'b0; mem_rw = 1'b0; fault = 1'b0;
        case (state_q)
            S_FETCH0: begin
                ma = 2'd2; md = 1'b1; op = OP_PASS_A; mar_ld = 1'b1;
            end
            S_FETCH1: begin
                ma = 2'd2; md = 1'b1; op = OP_ADD4; mc = 3'd3; rf_ld = 1'b1;
                mem_en = 1'b1; mem_rw = 1'b1;
            end
            S_FETCH2: begin
                mem_en = 1'b1; mem_rw = 1'b1; ir_ld = moc;
            end
            S_DP: begin
                mb = 2'd1;
                rf_ld    = (ir[24:23] != 2'b10);
                flags_ld = ir[20];
            end
            S_MEM_ADDR: begin
                mb = 2'd1; md = 1'b1; mar_ld = 1'b1;
                op = ir[23] ? OP_ADD : OP_SUB;
                if (!ir[20]) begin
                    mj = 2'd2; me = 1'b1; mdr_ld = 1'b1;
                end
            end
            S_LDR_WAIT: begin
                mem_en = 1'b1; mem_rw = 1'b1; mg = 1'b1; mdr_ld = moc;
            end
            S_LDR_WB: begin
                mb = 2'd2; md = 1'b1; op = OP_PASS_B; rf_ld = 1'b1;
            end
            S_STR_WAIT: mem_en = 1'b1;
            S_BL_LINK: begin
                ma = 2'd2; md = 1'b1; op = OP_PASS_A; mc = 3'd2; rf_ld = 1'b1;
            end
            S_BR: begin
                ma = 2'd2; mb = 2'd1; md = 1'b1; op = OP_ADD; mc = 3'd3; rf_ld = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: one default-timeout instance for instruction flows,
// one with a short MOC timeout for the watchdog and mid-wait reset.
module tb_ctrl_sequencer;

    typedef struct packed {
        logic [1:0] ma;
        logic [1:0] mb;
        logic [2:0] mc;
        logic       md, me, mg;
        logic [1:0] mj;
        logic [4:0] op;
        logic       rf_ld, ir_ld, mar_ld, mdr_ld, flags_ld, mem_en, mem_rw, fault;
    } outs_t;

    typedef struct packed {
        logic [4:0] st;
        outs_t      o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, rst_w = 1'b0;
    logic [31:0] ir = 32'hE0812003;
    logic        cond_ok = 1'b1;
    logic        moc = 1'b1, moc_w = 1'b0;

    logic [1:0] ma, mb, mj, ma_w, mb_w, mj_w;
    logic [2:0] mc, mc_w;
    logic       md, me, mg, md_w, me_w, mg_w;
    logic [4:0] op, op_w, state, state_w;
    logic       rf_ld, ir_ld, mar_ld, mdr_ld, flags_ld, mem_en, mem_rw, fault;
    logic       rf_ld_w, ir_ld_w, mar_ld_w, mdr_ld_w, flags_ld_w, mem_en_w, mem_rw_w, fault_w;

    outs_t o_main, o_wd;
    assign o_main = {ma, mb, mc, md, me, mg, mj, op, rf_ld, ir_ld, mar_ld, mdr_ld, flags_ld, mem_en, mem_rw, fault};
    assign o_wd   = {ma_w, mb_w, mc_w, md_w, me_w, mg_w, mj_w, op_w, rf_ld_w, ir_ld_w, mar_ld_w,
                     mdr_ld_w, flags_ld_w, mem_en_w, mem_rw_w, fault_w};

    int n_vec = 0;
    int n_err = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ctrl_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .cond_ok(cond_ok), .moc(moc),
        .ma(ma), .mb(mb), .mc(mc), .md(md), .me(me), .mg(mg), .mj(mj), .op(op),
        .rf_ld(rf_ld), .ir_ld(ir_ld), .mar_ld(mar_ld), .mdr_ld(mdr_ld), .flags_ld(flags_ld),
        .mem_en(mem_en), .mem_rw(mem_rw), .fault(fault), .state(state)
    );

    ctrl_sequencer #(.MOC_TIMEOUT(4)) dut_wd (
        .clk(clk), .rst_n(rst_w), .ir(ir), .cond_ok(cond_ok), .moc(moc_w),
        .ma(ma_w), .mb(mb_w), .mc(mc_w), .md(md_w), .me(me_w), .mg(mg_w), .mj(mj_w), .op(op_w),
        .rf_ld(rf_ld_w), .ir_ld(ir_ld_w), .mar_ld(mar_ld_w), .mdr_ld(mdr_ld_w), .flags_ld(flags_ld_w),
        .mem_en(mem_en_w), .mem_rw(mem_rw_w), .fault(fault_w), .state(state_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Expected select/strobe pattern for a state, written from the state table.
    function automatic outs_t spec_out(input logic [4:0] st, input logic [31:0] i, input logic m);
        outs_t o = '0;
        case (st)
            5'd1:  begin o.ma = 2; o.md = 1; o.op = 5'h10; o.mar_ld = 1; end
            5'd2:  begin o.ma = 2; o.md = 1; o.op = 5'h11; o.mc = 3; o.rf_ld = 1; o.mem_en = 1; o.mem_rw = 1; end
            5'd3:  begin o.mem_en = 1; o.mem_rw = 1; o.ir_ld = m; end
            5'd5:  begin o.mb = 1; o.rf_ld = (i[24:23] == 2'b10) ? 1'b0 : 1'b1; o.flags_ld = i[20]; end
            5'd6:  begin
                o.mb = 1; o.md = 1; o.mar_ld = 1; o.op = i[23] ? 5'h04 : 5'h02;
                if (i[20] == 1'b0) begin o.mj = 2; o.me = 1; o.mdr_ld = 1; end
            end
            5'd7:  begin o.mem_en = 1; o.mem_rw = 1; o.mg = 1; o.mdr_ld = m; end
            5'd8:  begin o.mb = 2; o.md = 1; o.op = 5'h12; o.rf_ld = 1; end
            5'd9:  begin o.mem_en = 1; end
            5'd10: begin o.ma = 2; o.md = 1; o.op = 5'h10; o.mc = 2; o.rf_ld = 1; end
            5'd11: begin o.ma = 2; o.mb = 1; o.md = 1; o.op = 5'h04; o.mc = 3; o.rf_ld = 1; end
            5'd31: begin o.fault = 1; end
            default: ;
        endcase
        return o;
    endfunction

    // Drive moc, push the expectation, compare at the falling edge, advance one clock.
    task automatic step(input bit wd, input logic m, input logic [4:0] st, input string tag);
        exp_t e;
        if (wd) moc_w = m; else moc = m;
        exp_q.push_back({st, spec_out(st, ir, m)});
        @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, "/state"}, 32'(wd ? state_w : state), 32'(e.st));
        chk({tag, "/outs"},  32'(wd ? o_wd : o_main),    32'(e.o));
        @(posedge clk);
        #1;
    endtask

    task automatic run_fetch(input string tag);
        step(0, 1'b1, 5'd1, {tag, "/FETCH0"});
        step(0, 1'b1, 5'd2, {tag, "/FETCH1"});
        step(0, 1'b1, 5'd3, {tag, "/FETCH2"});
        step(0, 1'b1, 5'd4, {tag, "/DECODE"});
    endtask

    initial begin
        exp_t e;
        #2;
        chk("reset/state", 32'(state), 32'd0);
        chk("reset/outs", 32'(o_main), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(0, 1'b1, 5'd0, "add/IDLE");

        ir = 32'hE0812003;
        run_fetch("add");
        step(0, 1'b1, 5'd5, "add/DP");

        ir = 32'hE1510002;
        run_fetch("cmp");
        step(0, 1'b1, 5'd5, "cmp/DP");

        ir = 32'hE5912004;
        run_fetch("ldr");
        step(0, 1'b1, 5'd6, "ldr/MEM_ADDR");
        for (int k = 0; k < 3; k++) step(0, 1'b0, 5'd7, "ldr/WAIT_lo");
        step(0, 1'b1, 5'd7, "ldr/WAIT_moc");
        step(0, 1'b1, 5'd8, "ldr/WB");

        ir = 32'hE5812004;
        run_fetch("str");
        step(0, 1'b1, 5'd6, "str/MEM_ADDR");
        step(0, 1'b1, 5'd9, "str/WAIT");

        ir = 32'hEB000010;
        run_fetch("bl");
        step(0, 1'b1, 5'd10, "bl/LINK");
        step(0, 1'b1, 5'd11, "bl/BR");

        ir = 32'h0A000000; cond_ok = 1'b0;
        run_fetch("nop");

        // MOC arriving on the last permitted wait cycle must beat the watchdog.
        step(0, 1'b1, 5'd1, "wdedge/FETCH0");
        step(0, 1'b1, 5'd2, "wdedge/FETCH1");
        for (int k = 0; k < 14; k++) step(0, 1'b0, 5'd3, "wdedge/FETCH2_lo");
        step(0, 1'b1, 5'd3, "wdedge/FETCH2_moc");
        step(0, 1'b1, 5'd4, "wdedge/DECODE");
        step(0, 1'b1, 5'd1, "wdedge/FETCH0_again");
        chk("wdedge/fault", 32'(fault), 32'd0);

        rst_w = 1'b1;
        step(1, 1'b0, 5'd0, "wd/IDLE");
        step(1, 1'b0, 5'd1, "wd/FETCH0");
        step(1, 1'b0, 5'd2, "wd/FETCH1");
        for (int k = 0; k < 4; k++) step(1, 1'b0, 5'd3, "wd/FETCH2_lo");
        step(1, 1'b0, 5'd31, "wd/FAULT");
        step(1, 1'b1, 5'd31, "wd/FAULT_moc");
        step(1, 1'b0, 5'd31, "wd/FAULT_sticky");

        rst_w = 1'b0;
        @(posedge clk); #1;
        rst_w = 1'b1;
        step(1, 1'b0, 5'd0, "rst/IDLE");
        step(1, 1'b0, 5'd1, "rst/FETCH0");
        step(1, 1'b0, 5'd2, "rst/FETCH1");
        step(1, 1'b0, 5'd3, "rst/FETCH2_lo");
        step(1, 1'b0, 5'd3, "rst/FETCH2_lo2");
        rst_w = 1'b0;
        exp_q.push_back({5'd0, outs_t'('0)});
        #2;
        e = exp_q.pop_front();
        chk("rst/midwait_state", 32'(state_w), 32'(e.st));
        chk("rst/midwait_outs", 32'(o_wd), 32'(e.o));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
